// File: rtl/vga_pattern_engine.sv
// vga_pattern_engine
//
// Parametrised VGA timing and test-pattern generator. It counts pixel
// clocks across each line and lines across each frame, then produces:
// horizontal and vertical sync with configurable porches and polarity,
// a registered pixel position, and one of six selectable test patterns.
// Pattern selection is latched only at the frame boundary, so a frame is
// never drawn in two different modes.
//
// Optional feature macro: VGA_PATTERN_BORDER_EN
//   defined   -> the outermost ring of visible pixels is forced white in
//                every mode.
//   undefined -> pattern output is left unmodified.
//
// Ports
//   i_Clk          pixel clock; all logic runs on its rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_Mode[2:0]    requested pattern, sampled at the end of each frame
//   o_HSync        horizontal sync (polarity set by SYNC_ACTIVE_LOW)
//   o_VSync        vertical sync (polarity set by SYNC_ACTIVE_LOW)
//   o_Red/Green/Blue  pixel colour, COLOUR_BITS each; 0 outside active area
//   o_Active       high while the output pixel is visible
//   o_Col / o_Row  position of the current output pixel
//   o_Frame_Start  one-clock pulse with output pixel (0,0)
//
// All outputs are registered one clock behind the h/v counters and are
// mutually aligned.

module vga_pattern_engine #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 18,
    parameter int H_SYNC          = 92,
    parameter int H_BP            = 50,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int COLOUR_BITS     = 3,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CHECK_SHIFT     = 5,
    parameter int GRAD_SHIFT      = 5
) (
    input  logic                                                i_Clk,
    input  logic                                                i_Rst_L,
    input  logic [2:0]                                          i_Mode,
    output logic                                                o_HSync,
    output logic                                                o_VSync,
    output logic [COLOUR_BITS-1:0]                              o_Red,
    output logic [COLOUR_BITS-1:0]                              o_Green,
    output logic [COLOUR_BITS-1:0]                              o_Blue,
    output logic                                                o_Active,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        o_Col,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        o_Row,
    output logic                                                o_Frame_Start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_EDGE   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_EDGE   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    // Idle (deasserted) level of both sync outputs.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

`ifdef VGA_PATTERN_BORDER_EN
    localparam logic BORDER_EN = 1'b1;
`else
    localparam logic BORDER_EN = 1'b0;
`endif

    logic [HW-1:0]          h;
    logic [VW-1:0]          v;
    logic [2:0]             mode;
    logic [7:0]             frame_cnt;
    logic [2:0]             bar_idx;
    logic [BW-1:0]          bar_sub;

    logic                   pix_active;
    logic                   hs_on;
    logic                   vs_on;
    logic                   on_border;
    logic                   check_hit;
    logic                   bar_hit;
    logic [COLOUR_BITS-1:0] grey;
    logic [COLOUR_BITS-1:0] red_next;
    logic [COLOUR_BITS-1:0] green_next;
    logic [COLOUR_BITS-1:0] blue_next;

    // Raster counters plus the state that only changes at line or frame
    // boundaries. The bar index/sub-counter track h exactly: both clear
    // on the cycle h wraps to 0 and the index saturates at 7 so the
    // blanking part of the line just repeats bar 7 (masked anyway).
    // Mode and frame counter update on the last pixel of the frame so the
    // new values are in place when the counters hold (0,0).
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            h         <= '0;
            v         <= '0;
            mode      <= 3'd0;
            frame_cnt <= 8'd0;
            bar_idx   <= 3'd0;
            bar_sub   <= '0;
        end else if (h == H_LAST) begin
            h       <= '0;
            bar_idx <= 3'd0;
            bar_sub <= '0;
            if (v == V_LAST) begin
                v         <= '0;
                mode      <= i_Mode;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                v <= v + VW'(1);
            end
        end else begin
            h <= h + HW'(1);
            if (bar_sub == BAR_LAST) begin
                bar_sub <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_sub <= bar_sub + BW'(1);
            end
        end
    end

    // Pixel colour and sync levels for the current counter position.
    // Arithmetic is widened to 32 bits so that every bit of h, v and the
    // frame counter takes part and the shifts never run off the vector.
    always_comb begin
        pix_active = (h < H_ACT) && (v < V_ACT);
        hs_on      = (h >= HS_START) && (h < HS_END);
        vs_on      = (v >= VS_START) && (v < VS_END);
        on_border  = (h == '0) || (h == H_EDGE) || (v == '0) || (v == V_EDGE);
        check_hit  = (((32'(h) >> CHECK_SHIFT) ^ (32'(v) >> CHECK_SHIFT)) & 32'd1) != 32'd0;
        bar_hit    = ((32'(h) >> 5) & 32'd31) == (32'(frame_cnt) & 32'd31);
        grey       = COLOUR_BITS'(32'(h) >> GRAD_SHIFT);
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;

        case (mode)
            3'd1: begin
                red_next   = '1;
                green_next = '1;
                blue_next  = '1;
            end
            3'd2: begin
                red_next   = {COLOUR_BITS{bar_idx[2]}};
                green_next = {COLOUR_BITS{bar_idx[1]}};
                blue_next  = {COLOUR_BITS{bar_idx[0]}};
            end
            3'd3: begin
                if (check_hit) begin
                    red_next   = '1;
                    green_next = '1;
                    blue_next  = '1;
                end
            end
            3'd4: begin
                red_next   = grey;
                green_next = grey;
                blue_next  = grey;
            end
            3'd5: begin
                if (bar_hit) begin
                    red_next   = '1;
                    green_next = '1;
                    blue_next  = '1;
                end
            end
            default: begin
                red_next   = '0;
                green_next = '0;
                blue_next  = '0;
            end
        endcase

        if (BORDER_EN && on_border) begin
            red_next   = '1;
            green_next = '1;
            blue_next  = '1;
        end

        // Blanking wins over every pattern and the border.
        if (!pix_active) begin
            red_next   = '0;
            green_next = '0;
            blue_next  = '0;
        end
    end

    // Single output pipeline stage; everything here describes the pixel
    // the counters held on the previous clock.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_HSync       <= SYNC_IDLE;
            o_VSync       <= SYNC_IDLE;
            o_Red         <= '0;
            o_Green       <= '0;
            o_Blue        <= '0;
            o_Active      <= 1'b0;
            o_Col         <= '0;
            o_Row         <= '0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_HSync       <= hs_on ? ~SYNC_IDLE : SYNC_IDLE;
            o_VSync       <= vs_on ? ~SYNC_IDLE : SYNC_IDLE;
            o_Red         <= red_next;
            o_Green       <= green_next;
            o_Blue        <= blue_next;
            o_Active      <= pix_active;
            o_Col         <= h;
            o_Row         <= v;
            o_Frame_Start <= (h == '0) && (v == '0);
        end
    end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// tb_vga_pattern_engine
//
// Directed bench for vga_pattern_engine using a shrunken raster
// (64x8 visible inside an 80x12 total) so that many frames fit in a
// short run. Expected values are written out by hand from the pattern
// rules for that geometry. Border-ring pixels are expected white when
// VGA_PATTERN_BORDER_EN is defined and black otherwise.

module tb_vga_pattern_engine;

    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int CB       = 3;
    localparam int HW       = 7;
    localparam int VW       = 4;

    localparam logic [3*CB-1:0] WHITE = 9'h1FF;
`ifdef VGA_PATTERN_BORDER_EN
    localparam logic [3*CB-1:0] BORDER = 9'h1FF;
`else
    localparam logic [3*CB-1:0] BORDER = 9'h000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    mode;
    logic          o_HSync;
    logic          o_VSync;
    logic [CB-1:0] o_Red;
    logic [CB-1:0] o_Green;
    logic [CB-1:0] o_Blue;
    logic          o_Active;
    logic [HW-1:0] o_Col;
    logic [VW-1:0] o_Row;
    logic          o_Frame_Start;

    logic [3*CB-1:0] rgb;
    assign rgb = {o_Red, o_Green, o_Blue};

    int vectors     = 0;
    int miscompares = 0;

    vga_pattern_engine #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COLOUR_BITS(CB), .SYNC_ACTIVE_LOW(1), .CHECK_SHIFT(2), .GRAD_SHIFT(3)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_n),
        .i_Mode(mode),
        .o_HSync(o_HSync),
        .o_VSync(o_VSync),
        .o_Red(o_Red),
        .o_Green(o_Green),
        .o_Blue(o_Blue),
        .o_Active(o_Active),
        .o_Col(o_Col),
        .o_Row(o_Row),
        .o_Frame_Start(o_Frame_Start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=0x%0h required=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] m);
        rst_n = rst;
        mode  = m;
    endtask

    task automatic stepClock();
        @(negedge clk);
    endtask

    task automatic waitPixel(input int col, input int row);
        for (int n = 0; n < 2000; n++) begin
            if (int'(o_Col) == col && int'(o_Row) == row) return;
            stepClock();
        end
        checkOutput("waitPixel_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitFrameStart();
        stepClock();
        for (int n = 0; n < 2000; n++) begin
            if (o_Frame_Start) return;
            stepClock();
        end
        checkOutput("waitFrameStart_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkPixel(input string tag, input int col, input int row, input logic [3*CB-1:0] expected);
        waitPixel(col, row);
        checkOutput(tag, 32'(rgb), 32'(expected));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_flags"}, 32'({o_HSync, o_VSync, o_Active, o_Frame_Start}), 32'b1100);
        checkOutput({tag, "_rgb"}, 32'(rgb), 32'd0);
        checkOutput({tag, "_pos"}, 32'({o_Col, o_Row}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3*CB-1:0] bars [8];
        int hs_low, vs_low, act, white, stray, hs_first, vs_first;

        bars = '{9'b000_000_000, 9'b000_000_111, 9'b000_111_000, 9'b000_111_111,
                 9'b111_000_000, 9'b111_000_111, 9'b111_111_000, 9'b111_111_111};

        // Reset values, then first frame (mode 0 after reset even though 1 is requested).
        applyStimulus(1'b0, 3'd1);
        repeat (3) stepClock();
        checkResetState("reset");
        applyStimulus(1'b1, 3'd1);
        stepClock();
        checkOutput("first_frame_start", 32'(o_Frame_Start), 32'd1);
        checkOutput("first_pos", 32'({o_Col, o_Row}), 32'd0);
        checkOutput("first_active", 32'(o_Active), 32'd1);
        checkPixel("m0_top", 5, 0, BORDER);
        checkPixel("m0_left", 0, 3, BORDER);
        checkPixel("m0_inner", 5, 3, 9'h000);
        checkPixel("m0_right", 63, 3, BORDER);
        checkPixel("m0_blank", 64, 3, 9'h000);
        checkOutput("m0_blank_active", 32'(o_Active), 32'd0);
        checkPixel("m0_bottom", 5, 7, BORDER);

        // Mode 1 frame: scan it whole; request mode 3 on line 4.
        waitFrameStart();
        hs_low = 0; vs_low = 0; act = 0; white = 0; stray = 0; hs_first = -1; vs_first = -1;
        for (int n = 0; n < 2000; n++) begin
            if (o_Row == 4'd4 && o_Col == 7'd0) applyStimulus(1'b1, 3'd3);
            if (!o_HSync) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(o_Col);
            end
            if (!o_VSync) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(o_Row);
            end
            if (o_Active) begin
                act++;
                if (rgb == WHITE) white++;
            end else if (rgb != 9'h000) begin
                stray++;
            end
            stepClock();
            if (o_Frame_Start) break;
        end
        checkOutput("m1_hsync_clocks", 32'(hs_low), 32'd96);
        checkOutput("m1_hsync_first_col", 32'(hs_first), 32'd68);
        checkOutput("m1_vsync_clocks", 32'(vs_low), 32'd160);
        checkOutput("m1_vsync_first_row", 32'(vs_first), 32'd9);
        checkOutput("m1_active_count", 32'(act), 32'd512);
        checkOutput("m1_white_count", 32'(white), 32'd512);
        checkOutput("m1_blank_colour", 32'(stray), 32'd0);

        // Checkerboard with 4-pixel cells.
        checkPixel("m3_4_0", 4, 0, WHITE);
        checkPixel("m3_0_4", 0, 4, WHITE);
        checkPixel("m3_4_4", 4, 4, 9'h000);
        checkPixel("m3_12_4", 12, 4, 9'h000);
        checkPixel("m3_8_5", 8, 5, WHITE);
        applyStimulus(1'b1, 3'd2);
        waitFrameStart();

        // Colour bars, 8 pixels wide, checked at both ends of each bar.
        for (int i = 0; i < 8; i++) begin
            checkPixel($sformatf("m2_bar%0d_lo", i), (i == 0) ? 1 : i * 8, 1, bars[i]);
            checkPixel($sformatf("m2_bar%0d_hi", i), (i == 7) ? 62 : i * 8 + 7, 1, bars[i]);
        end
        applyStimulus(1'b1, 3'd4);
        waitFrameStart();

        // Grey gradient, step of 8 pixels.
        checkPixel("m4_c1", 1, 1, 9'h000);
        checkPixel("m4_c8", 8, 1, 9'b001_001_001);
        checkPixel("m4_c23", 23, 1, 9'b010_010_010);
        checkPixel("m4_c40", 40, 1, 9'b101_101_101);
        checkPixel("m4_c62", 62, 1, 9'b111_111_111);
        applyStimulus(1'b1, 3'd6);
        waitFrameStart();

        checkPixel("m6_black", 10, 3, 9'h000);
        applyStimulus(1'b1, 3'd5);
        waitFrameStart();

        // Moving bar: frame f since reset lights columns 32*(f mod 32) onward.
        for (int f = 6; f <= 33; f++) begin
            checkPixel($sformatf("m5_f%0d_c1", f), 1, 1, ((f % 32) == 0) ? WHITE : 9'h000);
            checkPixel($sformatf("m5_f%0d_c40", f), 40, 1, ((f % 32) == 1) ? WHITE : 9'h000);
            waitFrameStart();
        end

        // Asynchronous reset in the middle of a frame.
        waitPixel(0, 5);
        #2;
        applyStimulus(1'b0, 3'd5);
        #1;
        checkResetState("async_reset");
        repeat (2) stepClock();
        checkResetState("held_reset");
        applyStimulus(1'b1, 3'd5);
        stepClock();
        checkOutput("post_reset_frame_start", 32'(o_Frame_Start), 32'd1);
        checkOutput("post_reset_pos", 32'({o_Col, o_Row}), 32'd0);
        checkPixel("post_reset_mode0", 1, 1, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
